addr_rr_arbiter: RTL

ADDR_RR_ARBITER -- requirements
Module: addr_rr_arbiter

---
 rtl/addr_rr_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/addr_rr_arbiter.sv
// addr_rr_arbiter: three-master round-robin address-phase arbiter.
// A grant is issued from IDLE, held through the address handshake (ADDR),
// and then through the data/response phase (WAIT) until finish.
// Optional feature: define ARB_TIMEOUT_EN to add a WAIT-state watchdog that
// force-releases the grant after TIMEOUT_CYC cycles and pulses timeout.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no grant; arbitrate among req each cycle
//   ADDR  | grant issued, waiting for address handshake (hs)
//   WAIT  | address accepted, waiting for finish (or watchdog expiry)
module addr_rr_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       hs,
    input  logic       finish,
    output logic [2:0] grant,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] NO_GRANT_ID = 2'd3;

    // The watchdog counter is 16 bits wide, so the limit must fit.
    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_bad_timeout_cyc
        $error("addr_rr_arbiter: TIMEOUT_CYC must be in 2..65536");
    end

    state_t     state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic [1:0] grant_id_q, grant_id_d;
    logic [1:0] last_q, last_d;
    logic       busy_q, busy_d;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT_CYC - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
`endif

    // Round-robin pick: first set bit searching from (last+1) mod 3 with wrap.
    // Returns 3 when no request is set.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        int         start;
        int         idx;
        logic [1:0] sel;
        start = (last >= 2'd2) ? 0 : int'(last) + 1;
        sel   = NO_GRANT_ID;
        // Walk from the farthest candidate back so the nearest one wins.
        for (int k = 2; k >= 0; k--) begin
            idx = (start + k) % 3;
            if (r[idx]) sel = 2'(idx);
        end
        return sel;
    endfunction

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        logic [1:0] pick;
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        busy_d     = busy_q;
        pick       = rr_pick(req, last_q);
`ifdef ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pick != NO_GRANT_ID) begin
                    state_d    = ST_ADDR;
                    grant_d    = 3'b001 << pick;
                    grant_id_d = pick;
                    last_d     = pick;
                    busy_d     = 1'b1;
                end
            end
            ST_ADDR: begin
                if (hs && finish) begin
                    state_d    = ST_IDLE;
                    grant_d    = 3'b000;
                    grant_id_d = NO_GRANT_ID;
                    busy_d     = 1'b0;
                end else if (hs) begin
                    state_d = ST_WAIT;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else if ((req & grant_q) == 3'b000) begin
                    // Granted master withdrew before the handshake; last stays
                    // pointing at it so the others get the next turn.
                    state_d    = ST_IDLE;
                    grant_d    = 3'b000;
                    grant_id_d = NO_GRANT_ID;
                    busy_d     = 1'b0;
                end
            end
            ST_WAIT: begin
                if (finish) begin
                    state_d    = ST_IDLE;
                    grant_d    = 3'b000;
                    grant_id_d = NO_GRANT_ID;
                    busy_d     = 1'b0;
`ifdef ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d    = ST_IDLE;
                    grant_d    = 3'b000;
                    grant_id_d = NO_GRANT_ID;
                    busy_d     = 1'b0;
                    timeout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
`endif
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = 3'b000;
                grant_id_d = NO_GRANT_ID;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and registered outputs; synchronous reset gives M0 first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= 3'b000;
            grant_id_q <= NO_GRANT_ID;
            last_q     <= 2'd2;
            busy_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout  = timeout_q;
`else
    assign timeout  = 1'b0;
`endif

endmodule
